// File: rtl/sd_dat_block_rx.sv
// sd_dat_block_rx: SD DAT-line block receiver (1/4-bit) with per-lane CRC16 check and an NBUF-deep ring of block buffers
// Ports:
//   clk_25mhz, resetn        system clock, asynchronous active-low reset
//   sd_clk_rise, sd_d        sample strobe and synchronised DAT[3:0]
//   wide_bus, arm            bus width (1 = 4-bit) latched by the arm pulse that expects one block
//   busy                     block reception in progress
//   blk_done, crc_err,
//   timeout_err              one-cycle result pulses
//   blk_valid, blk_count     committed buffers pending
//   rd_addr, rd_data         byte read of the oldest committed buffer, 1-cycle latency
//   blk_release              frees the oldest committed buffer
module sd_dat_block_rx #(
   parameter int BLOCK_BYTES = 512,
   parameter int NBUF        = 2,
   parameter int TIMEOUT     = 65535
) (
   input  logic                           clk_25mhz,
   input  logic                           resetn,
   input  logic                           sd_clk_rise,
   input  logic [3:0]                     sd_d,
   input  logic                           wide_bus,
   input  logic                           arm,
   output logic                           busy,
   output logic                           blk_done,
   output logic                           crc_err,
   output logic                           timeout_err,
   output logic                           blk_valid,
   output logic [$clog2(NBUF):0]          blk_count,
   input  logic [$clog2(BLOCK_BYTES)-1:0] rd_addr,
   output logic [7:0]                     rd_data,
   input  logic                           blk_release
);
   localparam int AW = $clog2(BLOCK_BYTES);
   localparam int PW = $clog2(NBUF);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, STOP, COMMIT} state_t;
   state_t state, state_nx;
   logic mode, bad, accept, start, byte_last, stop_ok, good, tmo, commit, fail, rel;
   logic [3:0] sub;
   logic [AW-1:0] byte_cnt;
   logic [TW-1:0] tcnt;
   logic [6:0] sh;
   logic [7:0] new_byte;
   logic [3:0][15:0] crc, crc_upd;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_nx;
   logic [7:0] mem [NBUF*BLOCK_BYTES];
   always_comb begin
      accept    = state == IDLE && arm && blk_count < CW'(NBUF);
      start     = mode ? sd_d == 4'h0 : !sd_d[0];
      byte_last = mode ? sub[0] : sub[2:0] == 3'd7;
      new_byte  = mode ? {sh[3:0], sd_d} : {sh, sd_d[0]};
      stop_ok   = sd_d[0] && (!mode || &sd_d[3:1]);
      good      = !bad && stop_ok;
      tmo       = state == WAIT_START && sd_clk_rise && !start && tcnt == TW'(TIMEOUT - 1);
      commit    = state == STOP && sd_clk_rise && good;
      fail      = state == STOP && sd_clk_rise && !good;
      rel       = blk_release && blk_count != '0;
      count_nx  = blk_count + CW'(commit) - CW'(rel);
      for (int i = 0; i < 4; i++)
         crc_upd[i] = {crc[i][14:0], 1'b0} ^ ((sd_d[i] ^ crc[i][15]) ? 16'h1021 : 16'h0000);
   end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:       if (accept) state_nx = WAIT_START;
         WAIT_START: if (sd_clk_rise) state_nx = start ? DATA : tmo ? IDLE : WAIT_START;
         DATA:       if (sd_clk_rise && byte_last && byte_cnt == AW'(BLOCK_BYTES - 1)) state_nx = CRC;
         CRC:        if (sd_clk_rise && sub == 4'd15) state_nx = STOP;
         STOP:       if (sd_clk_rise) state_nx = good ? COMMIT : IDLE;
         COMMIT:     state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk_25mhz or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   always_ff @(posedge clk_25mhz or negedge resetn)
      if (!resetn) begin
         busy        <= 1'b0;
         blk_done    <= 1'b0;
         crc_err     <= 1'b0;
         timeout_err <= 1'b0;
         blk_valid   <= 1'b0;
         blk_count   <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         mode        <= 1'b0;
         bad         <= 1'b0;
         sub         <= '0;
         byte_cnt    <= '0;
         tcnt        <= '0;
         sh          <= '0;
         crc         <= '0;
      end else begin
         busy        <= accept | (busy & ~(commit | fail | tmo));
         blk_done    <= commit;
         crc_err     <= fail;
         timeout_err <= tmo;
         blk_count   <= count_nx;
         blk_valid   <= count_nx != '0;
         if (commit) wr_ptr <= wr_ptr + PW'(1);
         if (rel) rd_ptr <= rd_ptr + PW'(1);
         if (accept) begin
            mode     <= wide_bus;
            bad      <= 1'b0;
            sub      <= '0;
            byte_cnt <= '0;
            tcnt     <= '0;
            crc      <= '0;
         end
         if (sd_clk_rise && state == WAIT_START && !start) tcnt <= tcnt + TW'(1);
         if (sd_clk_rise && state == DATA) begin
            sh  <= new_byte[6:0];
            sub <= byte_last ? 4'd0 : sub + 4'd1;
            crc <= crc_upd;
            if (byte_last) byte_cnt <= byte_cnt + AW'(1);
         end
         // the locally computed CRC is shifted out MSB first and compared against the received bits
         if (sd_clk_rise && state == CRC) begin
            bad <= bad | (sd_d[0] != crc[0][15]) |
                   (mode && sd_d[3:1] != {crc[3][15], crc[2][15], crc[1][15]});
            for (int i = 0; i < 4; i++) crc[i] <= {crc[i][14:0], 1'b0};
            sub <= sub + 4'd1;
         end
      end
   always_ff @(posedge clk_25mhz)
      if (state == DATA && sd_clk_rise && byte_last) mem[{wr_ptr, byte_cnt}] <= new_byte;
   always_ff @(posedge clk_25mhz or negedge resetn)
      if (!resetn) rd_data <= '0;
      else rd_data <= mem[{rd_ptr, rd_addr}];
endmodule

// File: tb/tb_sd_dat_block_rx.sv
// tb_sd_dat_block_rx: randomized bench for sd_dat_block_rx against a queue-of-blocks reference model
module tb_sd_dat_block_rx;
   localparam int BB = 512;
   localparam int NB = 2;
   localparam int TO = 100;
   typedef logic [BB*8-1:0] block_t;
   logic clk_25mhz = 1'b0, resetn = 1'b0, sd_clk_rise = 1'b0, wide_bus = 1'b0, arm = 1'b0, blk_release = 1'b0;
   logic [3:0] sd_d = 4'hF;
   logic busy, blk_done, crc_err, timeout_err, blk_valid;
   logic [1:0] blk_count;
   logic [8:0] rd_addr = '0;
   logic [7:0] rd_data;
   logic [7:0] blk [BB];
   block_t model_q[$];
   int checks = 0, errors = 0;
   always #20 clk_25mhz = ~clk_25mhz;
   sd_dat_block_rx #(.BLOCK_BYTES(BB), .NBUF(NB), .TIMEOUT(TO)) dut (
      .clk_25mhz(clk_25mhz), .resetn(resetn), .sd_clk_rise(sd_clk_rise), .sd_d(sd_d),
      .wide_bus(wide_bus), .arm(arm), .busy(busy), .blk_done(blk_done), .crc_err(crc_err),
      .timeout_err(timeout_err), .blk_valid(blk_valid), .blk_count(blk_count),
      .rd_addr(rd_addr), .rd_data(rd_data), .blk_release(blk_release));
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [2:0] noise();
      return 3'($urandom);
   endfunction
   function automatic logic [15:0] lane_crc(input logic wide, input int lane);
      logic [15:0] c;
      logic b;
      c = 16'h0000;
      for (int n = 0; n < BB; n++)
         for (int k = 7; k >= 0; k--) begin
            if (wide && (k % 4) != lane) continue;
            b = blk[n][k];
            c = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
         end
      return c;
   endfunction
   task automatic tick();
      @(posedge clk_25mhz);
      #1;
   endtask
   task automatic strobe(input logic [3:0] d, input logic rel);
      repeat ($urandom_range(0, 1)) tick();
      sd_d = d;
      sd_clk_rise = 1'b1;
      blk_release = rel;
      tick();
      sd_clk_rise = 1'b0;
      blk_release = 1'b0;
      sd_d = 4'($urandom);
   endtask
   task automatic arm_pulse(input logic wide);
      arm = 1'b1;
      wide_bus = wide;
      tick();
      arm = 1'b0;
      wide_bus = 1'($urandom);
   endtask
   task automatic release_pulse();
      blk_release = 1'b1;
      tick();
      blk_release = 1'b0;
      if (model_q.size() > 0) void'(model_q.pop_front());
      check("release_count", blk_count, model_q.size());
      check("release_valid", blk_valid, model_q.size() != 0);
   endtask
   task automatic fill_random();
      for (int n = 0; n < BB; n++) blk[n] = 8'($urandom);
   endtask
   task automatic read_check(input int a);
      rd_addr = 9'(a);
      tick();
      check("rd_data", rd_data, model_q[0][a*8 +: 8]);
   endtask
   task automatic send(input logic wide, input logic [3:0][15:0] crcs, input logic [3:0] stop,
                       input int pre_idle, input logic rel_at_stop);
      for (int i = 0; i < pre_idle; i++) strobe(wide ? 4'hF : {noise(), 1'b1}, 1'b0);
      strobe(wide ? 4'h0 : {noise(), 1'b0}, 1'b0);
      for (int n = 0; n < BB; n++)
         if (wide) begin
            strobe(blk[n][7:4], 1'b0);
            strobe(blk[n][3:0], 1'b0);
         end else
            for (int k = 7; k >= 0; k--) strobe({noise(), blk[n][k]}, 1'b0);
      for (int k = 15; k >= 0; k--)
         strobe(wide ? {crcs[3][k], crcs[2][k], crcs[1][k], crcs[0][k]} : {noise(), crcs[0][k]}, 1'b0);
      check("pre_stop_busy", busy, 1);
      check("pre_stop_pulses", blk_done | crc_err, 0);
      strobe(wide ? stop : {noise(), stop[0]}, rel_at_stop);
   endtask
   // kind: 0 good, 1 corrupt one active lane CRC bit, 2 clear one active lane stop bit
   task automatic run_block(input logic wide, input int kind, input int pre_idle,
                            input logic rel_at_stop, input logic [16:0] ovr);
      logic [3:0][15:0] crcs;
      logic [3:0] stop;
      logic good;
      block_t pk;
      int lane, k;
      stop = 4'hF;
      for (int i = 0; i < 4; i++) crcs[i] = lane_crc(wide, i);
      if (ovr[16]) crcs[0] = ovr[15:0];
      lane = wide ? $urandom_range(0, 3) : 0;
      k = $urandom_range(0, 15);
      if (kind == 1) crcs[lane][k] = ~crcs[lane][k];
      if (kind == 2) stop[lane] = 1'b0;
      good = 1'b1;
      for (int i = 0; i < 4; i++)
         if (i == 0 || wide) good &= crcs[i] == lane_crc(wide, i) && stop[i];
      arm_pulse(wide);
      check("busy_on_arm", busy, 1);
      send(wide, crcs, stop, pre_idle, rel_at_stop);
      if (rel_at_stop && model_q.size() > 0) void'(model_q.pop_front());
      if (good) begin
         for (int n = 0; n < BB; n++) pk[n*8 +: 8] = blk[n];
         model_q.push_back(pk);
      end
      check("blk_done", blk_done, good);
      check("crc_err", crc_err, !good);
      check("timeout_err_blk", timeout_err, 0);
      check("busy_end", busy, 0);
      check("blk_count", blk_count, model_q.size());
      check("blk_valid", blk_valid, model_q.size() != 0);
      tick();
      check("done_pulse_end", blk_done, 0);
      check("err_pulse_end", crc_err, 0);
      check("blk_count_hold", blk_count, model_q.size());
   endtask
   task automatic timeout_run(input logic wide);
      arm_pulse(wide);
      check("busy_to_arm", busy, 1);
      for (int i = 0; i < TO - 1; i++) begin
         strobe(wide ? 4'hF : {noise(), 1'b1}, 1'b0);
         if (i == TO / 2) arm_pulse(~wide);
      end
      check("timeout_early", timeout_err, 0);
      check("busy_before_to", busy, 1);
      strobe(wide ? 4'hF : {noise(), 1'b1}, 1'b0);
      check("timeout_err", timeout_err, 1);
      check("busy_after_to", busy, 0);
      tick();
      check("timeout_pulse_end", timeout_err, 0);
   endtask
   initial begin
      repeat (3) tick();
      check("rst_busy", busy, 0);
      check("rst_done", blk_done, 0);
      check("rst_crc_err", crc_err, 0);
      check("rst_timeout", timeout_err, 0);
      check("rst_valid", blk_valid, 0);
      check("rst_count", blk_count, 0);
      check("rst_rd_data", rd_data, 0);
      resetn = 1'b1;
      tick();
      for (int n = 0; n < BB; n++) blk[n] = 8'hFF;
      run_block(1'b0, 0, $urandom_range(0, 20), 1'b0, {1'b1, 16'h7FA1});
      check("ff_block_done", model_q.size(), 1);
      for (int a = 0; a < BB; a++) begin
         rd_addr = 9'(a);
         tick();
         check("rd_ff", rd_data, 8'hFF);
      end
      release_pulse();
      run_block(1'b0, 0, 5, 1'b0, {1'b1, 16'h7FA0});
      run_block(1'b0, 2, 5, 1'b0, 17'h0);
      check("ff_bad_count", blk_count, 0);
      for (int n = 0; n < BB; n++) blk[n] = 8'(n);
      run_block(1'b1, 0, $urandom_range(0, TO - 1), 1'b0, 17'h0);
      rd_addr = 9'h012;
      tick();
      check("rd_0x12", rd_data, 8'h12);
      for (int i = 0; i < 8; i++) read_check($urandom_range(0, BB - 1));
      fill_random();
      run_block(1'b1, 1, $urandom_range(0, 30), 1'b0, 17'h0);
      fill_random();
      run_block(1'b1, 2, $urandom_range(0, 30), 1'b0, 17'h0);
      fill_random();
      run_block(1'b1, 0, TO - 1, 1'b0, 17'h0);
      check("full_count", blk_count, 2);
      arm_pulse(1'b1);
      check("arm_full_ignored", busy, 0);
      strobe(4'h0, 1'b0);
      for (int i = 0; i < 6; i++) strobe(4'($urandom), 1'b0);
      check("full_still_idle", busy, 0);
      check("full_no_done", blk_done, 0);
      for (int r = 0; r < 2; r++) begin
         read_check(0);
         read_check(BB - 1);
         read_check($urandom_range(0, BB - 1));
         release_pulse();
         fill_random();
         run_block(1'b1, 0, $urandom_range(0, 30), 1'b1, 17'h0);
         check("same_cycle_count", blk_count, 1);
         read_check(0);
         read_check($urandom_range(0, BB - 1));
         fill_random();
         run_block(r[0], 0, $urandom_range(0, 30), 1'b0, 17'h0);
         read_check(BB - 1);
      end
      release_pulse();
      arm_pulse(1'b1);
      strobe(4'h0, 1'b0);
      for (int i = 0; i < 100; i++) strobe(4'($urandom), 1'b0);
      #5 resetn = 1'b0;
      #1;
      check("mid_rst_busy", busy, 0);
      check("mid_rst_count", blk_count, 0);
      check("mid_rst_valid", blk_valid, 0);
      check("mid_rst_rd_data", rd_data, 0);
      model_q.delete();
      tick();
      resetn = 1'b1;
      tick();
      fill_random();
      run_block(1'b1, 0, $urandom_range(0, 30), 1'b0, 17'h0);
      read_check(0);
      read_check(BB - 1);
      for (int i = 0; i < 4; i++) read_check($urandom_range(0, BB - 1));
      timeout_run(1'b1);
      timeout_run(1'b0);
      check("to_count_kept", blk_count, 1);
      release_pulse();
      release_pulse();
      check("empty_release_ignored", blk_count, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
